mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS datapath. It replaces the single-cycle Ctrl/NPC pairing when the core shares one memory port with wait states.
- It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables and mux selects (PC, IR, register file, ALU, DM) from state plus the latched opcode/func.
- It counts retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: max cycles waiting for mem_ready in any memory state before abort.
- CNT_WIDTH, 32: width of instr_retired.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from the DECODE cycle onward
- func  in  6  IR[5:0]
- alu_zero  in  1  ALU compare result (zero flag)
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  load PC at the clock edge
- pc_src  out  2  00=ALU (PC+4), 01=branch target reg, 10=jump {PC[31:28],addr,00}, 11=rs
- ir_write  out  1  load IR from memory data
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write enable
- reg_dst  out  2  00=rt, 01=rd, 10=31
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
- alu_op  out  3  000 ADD, 001 SUB, 010 by-func, 011 OR, 100 SLT, 101 LUI, 110 AND
- imm_ext_mode  out  1  1=sign extend, 0=zero extend
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5
- illegal  out  1  one-cycle pulse on an unsupported instruction
- bus_err  out  1  one-cycle pulse on memory timeout
- instr_retired  out  CNT_WIDTH  retired-instruction count; wraps

Behaviour:
- Reset: while rst=1, all enables, pulses and selects are 0 (combinational gating). At the next edge: state=FETCH, wait counter=0, instr_retired=0, latched class cleared. Asserting rst mid-instruction aborts the instruction with no register or memory update; mem_write drops in the same cycle.
- FETCH:
  - Drive mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - Hold until mem_ready. In that cycle drive ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
- DECODE:
  - Drive alu_src_a=0, alu_src_b=11, alu_op=ADD, imm_ext_mode=1 (branch target into ALUOut).
  - Latch opcode/func into an internal class register.
  - j (02): pc_write, pc_src=10, go to FETCH.
  - jr (R-type, func 08): pc_write, pc_src=11, go to FETCH.
  - jal (03): go to WB.
  - lw (23), sw (2B), beq (04), bne (05), R-type, addi (08), addiu (09), slti (0A), andi (0C), ori (0D), lui (0F): go to EXEC.
  - Anything else: illegal=1, go to FETCH, not retired.
- EXEC:
  - R-type: a=1, b=00, op=010, go to WB.
  - addi/addiu: b=10, ADD, sign extend. slti: SLT, sign extend. andi: AND, zero extend. ori: OR, zero extend. lui: LUI. All use a=1 and go to WB.
  - lw/sw: a=1, b=10, ADD, sign extend; go to MEMRD or MEMWR.
  - beq/bne: a=1, b=00, SUB. pc_write = beq&alu_zero | bne&~alu_zero, pc_src=01; go to FETCH.
- MEMRD / MEMWR:
  - Hold mem_read (MEMRD) or mem_write (MEMWR) until mem_ready.
  - On mem_ready, MEMRD goes to WB and MEMWR goes to FETCH.
- WB:
  - reg_write=1 for exactly one cycle, then go to FETCH.
  - R-type: reg_dst=01, mem_to_reg=00. I-ALU: reg_dst=00, mem_to_reg=00. lw: reg_dst=00, mem_to_reg=01.
  - jal: reg_dst=10, mem_to_reg=10 (PC already holds PC+4), plus pc_write with pc_src=10 in the same cycle.
- Wait counter:
  - Resets on entry to every memory-wait state and increments each cycle mem_ready=0.
  - On reaching MEM_TIMEOUT with mem_ready=0: bus_err=1.
    - FETCH: restart the fetch (counter cleared, PC unchanged).
    - MEMRD/MEMWR: go to FETCH with no reg write; the instruction is not retired.
  - If mem_ready=1 in the same cycle as the limit, ready wins.
- instr_retired: increments on every transition into FETCH that completes a legal instruction, including not-taken branches. Wraps from 2^CNT_WIDTH-1 to 0.
- Latency with mem_ready held at 1: j/jr 2 cycles, beq/bne 3, jal 3, sw 4, R-type/I-ALU 4, lw 5.
- Outputs not listed for a state are 0.

Test Plan:
- Reset, then R-type addu with mem_ready=1 -> states 0,1,2,5,0; reg_write in cycle 4 only with reg_dst=01; instr_retired=1.
- lw with mem_ready low 3 cycles in MEMRD -> mem_read held 4 cycles, then WB with mem_to_reg=01; 8 cycles total.
- beq alu_zero=1, then bne alu_zero=1 -> pc_write=1 with pc_src=01 for the first only; instr_retired +2.
- jal -> in WB, reg_write, reg_dst=10, mem_to_reg=10, pc_write and pc_src=10 all in one cycle; next state FETCH.
- sw with mem_ready never asserted, MEM_TIMEOUT=4 -> bus_err pulse after 4 wait cycles, then FETCH, instr_retired unchanged; rst asserted in MEMWR -> mem_write=0 the same cycle, FETCH after the edge.
- opcode 3F -> illegal pulse in DECODE, then FETCH, no enables, count unchanged.

Source files
------------

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle MIPS sequencing controller (FETCH/DECODE/EXEC/MEM/WB)
//            with memory wait states, timeout abort and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           func,
    input  logic                 alu_zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_op,
    output logic                 imm_ext_mode,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [CNT_WIDTH-1:0] instr_retired
);

    localparam int c_WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_LIMIT = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE   = c_WAIT_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);

    localparam logic [2:0] c_S_FETCH  = 3'd0;
    localparam logic [2:0] c_S_DECODE = 3'd1;
    localparam logic [2:0] c_S_EXEC   = 3'd2;
    localparam logic [2:0] c_S_MEMRD  = 3'd3;
    localparam logic [2:0] c_S_MEMWR  = 3'd4;
    localparam logic [2:0] c_S_WB     = 3'd5;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_FUNC = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_SLT  = 3'b100;
    localparam logic [2:0] c_ALU_LUI  = 3'b101;
    localparam logic [2:0] c_ALU_AND  = 3'b110;

    // Instruction class, decoded once in DECODE and held for EXEC/MEM/WB
    localparam logic [3:0] c_CL_NONE  = 4'd0;
    localparam logic [3:0] c_CL_RTYPE = 4'd1;
    localparam logic [3:0] c_CL_ADDI  = 4'd2;
    localparam logic [3:0] c_CL_SLTI  = 4'd3;
    localparam logic [3:0] c_CL_ANDI  = 4'd4;
    localparam logic [3:0] c_CL_ORI   = 4'd5;
    localparam logic [3:0] c_CL_LUI   = 4'd6;
    localparam logic [3:0] c_CL_LW    = 4'd7;
    localparam logic [3:0] c_CL_SW    = 4'd8;
    localparam logic [3:0] c_CL_BEQ   = 4'd9;
    localparam logic [3:0] c_CL_BNE   = 4'd10;
    localparam logic [3:0] c_CL_JAL   = 4'd11;
    localparam logic [3:0] c_CL_J     = 4'd12;
    localparam logic [3:0] c_CL_JR    = 4'd13;

    logic [2:0]           r_state;
    logic [2:0]           w_nextState;
    logic [c_WAIT_W-1:0]  r_waitCnt;
    logic [3:0]           r_class;
    logic [3:0]           w_decClass;
    logic [CNT_WIDTH-1:0] r_retired;
    logic                 w_memWait;
    logic                 w_timeout;
    logic                 w_illegal;
    logic                 w_retire;

    always_comb begin
        w_decClass = c_CL_NONE;
        case (opcode)
            c_OP_RTYPE: w_decClass = (func == c_FN_JR) ? c_CL_JR : c_CL_RTYPE;
            c_OP_J:     w_decClass = c_CL_J;
            c_OP_JAL:   w_decClass = c_CL_JAL;
            c_OP_BEQ:   w_decClass = c_CL_BEQ;
            c_OP_BNE:   w_decClass = c_CL_BNE;
            c_OP_ADDI,
            c_OP_ADDIU: w_decClass = c_CL_ADDI;
            c_OP_SLTI:  w_decClass = c_CL_SLTI;
            c_OP_ANDI:  w_decClass = c_CL_ANDI;
            c_OP_ORI:   w_decClass = c_CL_ORI;
            c_OP_LUI:   w_decClass = c_CL_LUI;
            c_OP_LW:    w_decClass = c_CL_LW;
            c_OP_SW:    w_decClass = c_CL_SW;
            default:    w_decClass = c_CL_NONE;
        endcase
    end

    assign w_memWait = (r_state == c_S_FETCH) || (r_state == c_S_MEMRD) ||
                       (r_state == c_S_MEMWR);
    // A ready in the limit cycle completes the access instead of aborting it
    assign w_timeout = w_memWait && !mem_ready && (r_waitCnt == c_WAIT_LIMIT);
    assign w_illegal = (r_state == c_S_DECODE) && (w_decClass == c_CL_NONE);
    assign w_retire  = (w_nextState == c_S_FETCH) && (r_state != c_S_FETCH) &&
                       (r_state != c_S_MEMRD) && !w_timeout && !w_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_FETCH;
            r_waitCnt <= '0;
            r_class   <= c_CL_NONE;
            r_retired <= '0;
        end else begin
            r_state <= w_nextState;
            if ((w_nextState != r_state) || w_timeout) begin
                r_waitCnt <= '0;
            end else if (w_memWait && !mem_ready) begin
                r_waitCnt <= r_waitCnt + c_WAIT_ONE;
            end
            if (r_state == c_S_DECODE) begin
                r_class <= w_decClass;
            end
            if (w_retire) begin
                r_retired <= r_retired + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_S_FETCH: begin
                if (mem_ready) w_nextState = c_S_DECODE;
            end
            c_S_DECODE: begin
                case (w_decClass)
                    c_CL_J, c_CL_JR, c_CL_NONE: w_nextState = c_S_FETCH;
                    c_CL_JAL:                   w_nextState = c_S_WB;
                    default:                    w_nextState = c_S_EXEC;
                endcase
            end
            c_S_EXEC: begin
                case (r_class)
                    c_CL_LW:  w_nextState = c_S_MEMRD;
                    c_CL_SW:  w_nextState = c_S_MEMWR;
                    c_CL_RTYPE, c_CL_ADDI, c_CL_SLTI, c_CL_ANDI, c_CL_ORI,
                    c_CL_LUI: w_nextState = c_S_WB;
                    default:  w_nextState = c_S_FETCH;
                endcase
            end
            c_S_MEMRD: begin
                if (mem_ready)      w_nextState = c_S_WB;
                else if (w_timeout) w_nextState = c_S_FETCH;
            end
            c_S_MEMWR: begin
                if (mem_ready || w_timeout) w_nextState = c_S_FETCH;
            end
            default: w_nextState = c_S_FETCH;
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 2'b00;
        mem_to_reg   = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = c_ALU_ADD;
        imm_ext_mode = 1'b0;
        illegal      = 1'b0;
        bus_err      = 1'b0;
        if (!rst) begin
            case (r_state)
                c_S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    bus_err   = w_timeout;
                end
                c_S_DECODE: begin
                    alu_src_b    = 2'b11;
                    imm_ext_mode = 1'b1;
                    case (w_decClass)
                        c_CL_J: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                        end
                        c_CL_JR: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b11;
                        end
                        c_CL_NONE: illegal = 1'b1;
                        default: ;
                    endcase
                end
                c_S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (r_class)
                        c_CL_RTYPE: begin
                            alu_src_b = 2'b00;
                            alu_op    = c_ALU_FUNC;
                        end
                        c_CL_ADDI, c_CL_LW, c_CL_SW: imm_ext_mode = 1'b1;
                        c_CL_SLTI: begin
                            alu_op       = c_ALU_SLT;
                            imm_ext_mode = 1'b1;
                        end
                        c_CL_ANDI: alu_op = c_ALU_AND;
                        c_CL_ORI:  alu_op = c_ALU_OR;
                        c_CL_LUI:  alu_op = c_ALU_LUI;
                        c_CL_BEQ, c_CL_BNE: begin
                            alu_src_b = 2'b00;
                            alu_op    = c_ALU_SUB;
                            pc_src    = 2'b01;
                            pc_write  = (r_class == c_CL_BEQ) ? alu_zero : !alu_zero;
                        end
                        default: ;
                    endcase
                end
                c_S_MEMRD: begin
                    mem_read = 1'b1;
                    bus_err  = w_timeout;
                end
                c_S_MEMWR: begin
                    mem_write = 1'b1;
                    bus_err   = w_timeout;
                end
                c_S_WB: begin
                    reg_write = 1'b1;
                    case (r_class)
                        c_CL_RTYPE: reg_dst = 2'b01;
                        c_CL_LW:    mem_to_reg = 2'b01;
                        c_CL_JAL: begin
                            reg_dst    = 2'b10;
                            mem_to_reg = 2'b10;
                            pc_write   = 1'b1;
                            pc_src     = 2'b10;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign state         = r_state;
    assign instr_retired = r_retired;

endmodule
`default_nettype wire
